mac_drain: RTL and testbench

- Downstream stage of the MAC array row: captures the NUM_COLS accumulators after a compute pass.
- Requantizes each accumulator (arithmetic right shift, round-half-up, saturate) to a signed OUT_DATA_WIDTH value.
- Streams the results one per beat over a valid/ready interface toward the output buffer/UART path.

---
 rtl/utpu_pkg.sv | 21 ++
 rtl/requant_sat.sv | 39 +++
 rtl/mac_drain.sv | 141 ++++++++++++++
 tb/tb_mac_drain.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/utpu_pkg.sv
// Shared widths and the drain FSM state type for the MAC array output path.
package utpu_pkg;

    localparam int ACCUMULATOR_DATA_WIDTH = 16;
    localparam int COMPUTE_DATA_WIDTH     = 8;
    localparam int OUT_DATA_WIDTH         = 8;
    localparam int NUM_COLS_DEFAULT       = 4;
    localparam int COL_IDX_WIDTH          = $clog2(NUM_COLS_DEFAULT);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } drain_state_t;

    // A single-column build still needs a 1-bit index.
    function automatic int col_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/requant_sat.sv
// One accumulator requantized: arithmetic right shift with round-half-up,
// then saturated to a signed OUT-bit result. Purely combinational.
module requant_sat #(
    parameter int ACC         = 16,
    parameter int OUT         = 8,
    parameter int SHIFT_WIDTH = 4
) (
    input  logic [ACC-1:0]         acc,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [OUT-1:0]         q
);

    localparam logic signed [ACC:0] MAX_V = (ACC+1)'((2 ** (OUT - 1)) - 1);
    localparam logic signed [ACC:0] MIN_V = (ACC+1)'(-(2 ** (OUT - 1)));

    logic signed [ACC:0] a_ext;
    logic signed [ACC:0] half;
    logic signed [ACC:0] sum;
    logic signed [ACC:0] r;

    // One extra bit of headroom so the rounding add can never wrap.
    always_comb begin
        a_ext = $signed({acc[ACC-1], acc});
        half  = '0;
        if (shift != '0) begin
            half = (ACC+1)'(1) << (shift - SHIFT_WIDTH'(1));
        end
        sum = a_ext + half;
        r   = sum >>> shift;
        if (r > MAX_V) begin
            q = MAX_V[OUT-1:0];
        end else if (r < MIN_V) begin
            q = MIN_V[OUT-1:0];
        end else begin
            q = r[OUT-1:0];
        end
    end

endmodule

// File: rtl/mac_drain.sv
// Drains a snapshot of the MAC row accumulators as a stream of requantized
// beats, one column per accepted transfer, followed by a one-cycle done pulse.
module mac_drain
    import utpu_pkg::*;
#(
    parameter int NUM_COLS               = 4,
    parameter int ACCUMULATOR_DATA_WIDTH = utpu_pkg::ACCUMULATOR_DATA_WIDTH,
    parameter int OUT_DATA_WIDTH         = utpu_pkg::OUT_DATA_WIDTH,
    parameter int SHIFT_WIDTH            = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [NUM_COLS*ACCUMULATOR_DATA_WIDTH-1:0] acc_in,
    input  logic [SHIFT_WIDTH-1:0]                     shift,
    output logic                                       busy,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [OUT_DATA_WIDTH-1:0]                  out_data,
    output logic [col_w(NUM_COLS)-1:0]                 out_col,
    output logic                                       out_last,
    output logic                                       done
);

    localparam int ACC   = ACCUMULATOR_DATA_WIDTH;
    localparam int OUT   = OUT_DATA_WIDTH;
    localparam int COL_W = col_w(NUM_COLS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    drain_state_t                      state_q, state_d;
    logic [NUM_COLS-1:0][ACC-1:0]      snap_q, snap_d;
    logic [SHIFT_WIDTH-1:0]            shift_q, shift_d;
    logic [COL_W-1:0]                  col_q, col_d;
    logic [OUT-1:0]                    data_q, data_d;
    logic                              valid_q, valid_d;
    logic                              last_q, last_d;

    logic [SHIFT_WIDTH-1:0]            shift_clamped;
    logic [COL_W-1:0]                  nxt_col;
    logic [NUM_COLS-1:0][ACC-1:0]      acc_cols;
    logic [ACC-1:0]                    rq_acc;
    logic [SHIFT_WIDTH-1:0]            rq_shift;
    logic [OUT-1:0]                    rq_out;

    assign acc_cols      = acc_in;
    assign shift_clamped = (int'(shift) >= ACC) ? SHIFT_WIDTH'(ACC - 1) : shift;
    assign nxt_col       = col_q + COL_W'(1);

    // The requantizer always sees the column that will be presented next:
    // column 0 straight from the input on capture, otherwise the snapshot.
    always_comb begin
        if (state_q == IDLE) begin
            rq_acc   = acc_cols[0];
            rq_shift = shift_clamped;
        end else begin
            rq_acc   = snap_q[nxt_col];
            rq_shift = shift_q;
        end
    end

    requant_sat #(
        .ACC         (ACC),
        .OUT         (OUT),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_requant (
        .acc   (rq_acc),
        .shift (rq_shift),
        .q     (rq_out)
    );

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        shift_d = shift_q;
        col_d   = col_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = acc_cols;
                    shift_d = shift_clamped;
                    col_d   = '0;
                    data_d  = rq_out;
                    valid_d = 1'b1;
                    last_d  = (NUM_COLS == 1);
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (valid_q && out_ready) begin
                    if (col_q == LAST_COL) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        col_d  = nxt_col;
                        data_d = rq_out;
                        last_d = (nxt_col == LAST_COL);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            shift_q <= '0;
            col_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            shift_q <= shift_d;
            col_q   <= col_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Status comes straight off the state flop so reset clears it at once.
    assign busy      = (state_q == STREAM);
    assign done      = (state_q == DONE);
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_col   = col_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_mac_drain.sv
// Self-checking bench for mac_drain: table vectors, hand-written corner
// sequences, and randomized drains against an arithmetic reference model.
module tb_mac_drain;

    localparam int NC = 4;
    localparam int AW = 16;
    localparam int OW = 8;
    localparam int SW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              out_ready = 1'b0;
    logic [NC*AW-1:0]  acc_in = '0;
    logic [SW-1:0]     shift = '0;
    logic              busy, out_valid, out_last, done;
    logic [OW-1:0]     out_data;
    logic [1:0]        out_col;

    int n_cmp = 0;
    int n_bad = 0;
    int got_data[$];
    int got_col[$];
    int got_last[$];
    int done_cnt;

    typedef struct {
        int acc[NC];
        int sh;
        int exp[NC];
    } vec_t;
    vec_t vecs[6];

    mac_drain #(
        .NUM_COLS               (NC),
        .ACCUMULATOR_DATA_WIDTH (AW),
        .OUT_DATA_WIDTH         (OW),
        .SHIFT_WIDTH            (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .acc_in    (acc_in),
        .shift     (shift),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_col   (out_col),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference: divide by 2^s after adding half, rounding toward -inf, then clip.
    function automatic int ref_q(input int a, input int s);
        int d, r, q;
        if (s >= AW) s = AW - 1;
        if (s == 0) begin
            r = a;
        end else begin
            d = 1 << s;
            r = a + d / 2;
            q = r / d;
            if (r < 0 && q * d != r) q = q - 1;
            r = q;
        end
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    function automatic logic [NC*AW-1:0] pack(input int a[NC]);
        logic [NC*AW-1:0] p;
        p = '0;
        for (int c = 0; c < NC; c++) p[c*AW +: AW] = AW'(a[c]);
        return p;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Sample on the falling edge; change ready/start just after the rising edge.
    task automatic collect(input bit rnd_ready, input bit disturb);
        got_data.delete();
        got_col.delete();
        got_last.delete();
        done_cnt = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got_data.push_back(int'($signed(out_data)));
                got_col.push_back(int'(out_col));
                got_last.push_back(int'(out_last));
            end
            if (done) begin
                done_cnt++;
                check("busy_at_done", int'(busy), 0);
                break;
            end
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (disturb) begin
                start  = 1'($urandom_range(0, 1));
                acc_in = {$urandom, $urandom};
            end
        end
        check("done_seen", done_cnt, 1);
        @(posedge clk);
        #1;
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("idle_valid", int'(out_valid), 0);
    endtask

    task automatic run_drain(input logic [NC*AW-1:0] acc, input int sh,
                             input bit rnd_ready, input bit disturb);
        @(posedge clk);
        #1;
        acc_in    = acc;
        shift     = SW'(sh);
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = disturb;
        check("first_valid", int'(out_valid), 1);
        check("first_busy", int'(busy), 1);
        check("first_col", int'(out_col), 0);
        if (disturb) acc_in = ~acc;
        collect(rnd_ready, disturb);
    endtask

    task automatic check_beats(input int exp[NC], input int first);
        check("beat_count", got_data.size(), NC - first);
        for (int i = 0; i < got_data.size() && i < NC - first; i++) begin
            check($sformatf("data[%0d]", i + first), got_data[i], exp[i + first]);
            check($sformatf("col[%0d]", i + first), got_col[i], i + first);
            check($sformatf("last[%0d]", i + first), got_last[i], int'(i + first == NC - 1));
        end
    endtask

    initial begin
        int a[NC];
        int e[NC];
        int sh;

        vecs[0].acc = '{100, -100, 300, -300};    vecs[0].sh = 0;  vecs[0].exp = '{100, -100, 127, -128};
        vecs[1].acc = '{6, -6, 5, 32767};         vecs[1].sh = 2;  vecs[1].exp = '{2, -1, 1, 127};
        vecs[2].acc = '{-32768, 32767, -1, 1};    vecs[2].sh = 15; vecs[2].exp = '{-1, 1, 0, 0};
        vecs[3].acc = '{-3, 3, -4, 255};          vecs[3].sh = 1;  vecs[3].exp = '{-1, 2, -2, 127};
        vecs[4].acc = '{127, -128, 128, -129};    vecs[4].sh = 0;  vecs[4].exp = '{127, -128, 127, -128};
        vecs[5].acc = '{1000, -1000, 24, -24};    vecs[5].sh = 4;  vecs[5].exp = '{63, -62, 2, -1};

        #7;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_last", int'(out_last), 0);
        check("rst_done", int'(done), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_col", int'(out_col), 0);
        #5;
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_drain(pack(vecs[i].acc), vecs[i].sh, 1'b0, 1'b0);
            check_beats(vecs[i].exp, 0);
        end

        // Backpressure while column 1 is presented.
        @(posedge clk);
        #1;
        acc_in = pack(vecs[1].acc); shift = 4'd2; start = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_valid", int'(out_valid), 1);
            check("bp_col", int'(out_col), 1);
            check("bp_data", int'($signed(out_data)), -1);
            check("bp_last", int'(out_last), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        collect(1'b0, 1'b0);
        check_beats(vecs[1].exp, 1);

        // Re-start and input churn during the drain must not disturb it.
        run_drain(pack(vecs[0].acc), 0, 1'b1, 1'b1);
        check_beats(vecs[0].exp, 0);

        // Asynchronous reset while column 2 is presented.
        @(posedge clk);
        #1;
        acc_in = pack(vecs[0].acc); shift = 4'd0; start = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_rst_col", int'(out_col), 2);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_col", int'(out_col), 0);
        check("arst_done", int'(done), 0);
        #3;
        rst = 1'b1;
        a = '{1, 2, 3, 4};
        e = '{1, 2, 3, 4};
        run_drain(pack(a), 0, 1'b0, 1'b0);
        check_beats(e, 0);

        // Randomized drains against the model.
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < NC; c++) begin
                case ($urandom_range(0, 5))
                    0:       a[c] = -32768;
                    1:       a[c] = 32767;
                    2:       a[c] = $urandom_range(0, 600) - 300;
                    default: a[c] = $urandom_range(0, 65535) - 32768;
                endcase
            end
            sh = $urandom_range(0, 15);
            for (int c = 0; c < NC; c++) e[c] = ref_q(a[c], sh);
            run_drain(pack(a), sh, 1'b1, 1'($urandom_range(0, 1)));
            check_beats(e, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
